run_controller: RTL

RUN_CONTROLLER -- requirements
Module: run_controller

---
 rtl/run_controller.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/run_controller.sv
// run_controller: launches a core by holding it in reset for a fixed number
// of cycles, lets it run against a cycle budget, and snoops its data-memory
// port for the termination ("tohost") store. The run ends on that store or
// when the budget runs out.
//
// Optional feature: define RUN_CONTROLLER_STORE_COUNT_EN to count the core's
// stores during RUN. Without it, store_count is tied to zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | core held in reset, waiting for start
// HOLD  | core held in reset for RESET_CYCLES cycles, results cleared
// RUN   | core released, cycle budget counting, stores snooped
// DONE  | core held in reset, results frozen until the next start

module run_controller #(
  parameter int unsigned       RESET_CYCLES = 5,
  parameter int unsigned       MAX_CYCLES   = 120,
  parameter int unsigned       ADDR_W       = 6,
  parameter int unsigned       DATA_W       = 64,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = 6'h3F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              d_mem_we,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_data,
  output logic              core_rst_n,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [31:0]       cycle_count,
  output logic [DATA_W-1:0] result,
  output logic [15:0]       store_count
);

  // RESET_CYCLES of 0 or 1 both give a single HOLD cycle.
  localparam int HOLD_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [31:0]         r_budget;
  logic                r_core_rst_n;
  logic                r_running;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic [31:0]         r_cycle_count;
  logic [DATA_W-1:0]   r_result;

  logic                w_enter_hold;
  logic                w_hold_tc;
  logic                w_budget_tc;
  logic                w_tohost;
  logic                w_in_run;

  assign w_in_run  = (r_state == S_RUN);
  assign w_tohost  = d_mem_we && (d_mem_addr == TOHOST_ADDR);
  assign w_hold_tc = (r_hold_cnt <= HOLD_W'(1));
  // Budget is a down-counter loaded with MAX_CYCLES-1; zero marks the last
  // RUN cycle.
  assign w_budget_tc = (r_budget == 32'd0);

  // Next-state decode; start only matters in IDLE and DONE.
  always_comb begin
    w_state_nxt  = r_state;
    w_enter_hold = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt  = S_HOLD;
          w_enter_hold = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_hold_tc) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_tohost || w_budget_tc) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_state_nxt  = S_HOLD;
          w_enter_hold = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // HOLD duration timer, reloaded on every launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (w_enter_hold) begin
      r_hold_cnt <= HOLD_W'(RESET_CYCLES);
    end else if ((r_state == S_HOLD) && !w_hold_tc) begin
      r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
    end
  end

  // RUN budget timer, reloaded on every launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_budget <= '0;
    end else if (w_enter_hold) begin
      r_budget <= 32'(MAX_CYCLES - 1);
    end else if (w_in_run && !w_budget_tc) begin
      r_budget <= r_budget - 32'd1;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_core_rst_n <= 1'b0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_core_rst_n <= (w_state_nxt == S_RUN);
      r_running    <= (w_state_nxt == S_RUN);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  // Run results: cleared at launch, updated only in RUN, frozen otherwise.
  // A tohost store on the last budget cycle takes priority over timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_result      <= '0;
    end else if (w_enter_hold) begin
      r_pass        <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
      r_result      <= '0;
    end else if (w_in_run) begin
      if (r_cycle_count != 32'hFFFF_FFFF) begin
        r_cycle_count <= r_cycle_count + 32'd1;
      end
      if (w_tohost) begin
        r_result  <= d_mem_data;
        r_pass    <= (d_mem_data == DATA_W'(1));
        r_timeout <= 1'b0;
      end else if (w_budget_tc) begin
        r_pass    <= 1'b0;
        r_timeout <= 1'b1;
      end
    end
  end

`ifdef RUN_CONTROLLER_STORE_COUNT_EN
  logic [15:0] r_store_count;

  // Count every core store seen during RUN, tohost included, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store_count <= '0;
    end else if (w_enter_hold) begin
      r_store_count <= '0;
    end else if (w_in_run && d_mem_we && (r_store_count != 16'hFFFF)) begin
      r_store_count <= r_store_count + 16'd1;
    end
  end

  assign store_count = r_store_count;
`else
  assign store_count = 16'h0000;
`endif

  assign core_rst_n  = r_core_rst_n;
  assign running     = r_running;
  assign done        = r_done;
  assign pass        = r_pass;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign result      = r_result;

endmodule
